// File: rtl/reg_read_stage_if.sv
// Issue, PRF read, bypass, flush and execute-side signals of one register-read lane.
// The master modport is the environment around the stage; the slave modport is the stage itself.
interface reg_read_stage_if #(
    parameter int unsigned NUM_FUS   = 4,
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned PREG_W    = $clog2(NUM_PREGS),
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned CTRL_W    = 16
);
    logic                      iss_valid;
    logic                      iss_ready;
    logic [PREG_W-1:0]         iss_src1_reg;
    logic [PREG_W-1:0]         iss_src2_reg;
    logic                      iss_src1_used;
    logic                      iss_src2_used;
    logic [PREG_W-1:0]         iss_dst_reg;
    logic [TAG_W-1:0]          iss_tag;
    logic [CTRL_W-1:0]         iss_ctrl;

    logic [PREG_W-1:0]         prf_src1_reg;
    logic [PREG_W-1:0]         prf_src2_reg;
    logic [31:0]               prf_src1_val;
    logic [31:0]               prf_src2_val;

    logic [NUM_FUS-1:0]        bp_valid;
    logic [NUM_FUS*PREG_W-1:0] bp_dst_reg;
    logic [NUM_FUS*32-1:0]     bp_val;

    logic                      flush;

    logic                      ex_valid;
    logic                      ex_ready;
    logic [31:0]               ex_src1_val;
    logic [31:0]               ex_src2_val;
    logic [PREG_W-1:0]         ex_dst_reg;
    logic [TAG_W-1:0]          ex_tag;
    logic [CTRL_W-1:0]         ex_ctrl;

    modport master (
        output iss_valid, iss_src1_reg, iss_src2_reg, iss_src1_used, iss_src2_used,
               iss_dst_reg, iss_tag, iss_ctrl,
        input  iss_ready,
        input  prf_src1_reg, prf_src2_reg,
        output prf_src1_val, prf_src2_val,
        output bp_valid, bp_dst_reg, bp_val,
        output flush,
        input  ex_valid, ex_src1_val, ex_src2_val, ex_dst_reg, ex_tag, ex_ctrl,
        output ex_ready
    );

    modport slave (
        input  iss_valid, iss_src1_reg, iss_src2_reg, iss_src1_used, iss_src2_used,
               iss_dst_reg, iss_tag, iss_ctrl,
        output iss_ready,
        output prf_src1_reg, prf_src2_reg,
        input  prf_src1_val, prf_src2_val,
        input  bp_valid, bp_dst_reg, bp_val,
        input  flush,
        output ex_valid, ex_src1_val, ex_src2_val, ex_dst_reg, ex_tag, ex_ctrl,
        input  ex_ready
    );
endinterface

// File: rtl/reg_read_stage.sv
// Register-read stage for one FU lane: PRF read from the RR slot, same-cycle writeback
// bypass, and a registered OUT slot toward execute with valid/ready backpressure and flush.
module reg_read_stage #(
    parameter int unsigned NUM_FUS   = 4,
    parameter int unsigned NUM_PREGS = 64,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned CTRL_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    reg_read_stage_if.slave   io
);
    localparam int unsigned PREG_W = $clog2(NUM_PREGS);

    logic              rr_valid;
    logic [PREG_W-1:0] rr_src1_reg;
    logic [PREG_W-1:0] rr_src2_reg;
    logic              rr_src1_used;
    logic              rr_src2_used;
    logic [PREG_W-1:0] rr_dst_reg;
    logic [TAG_W-1:0]  rr_tag;
    logic [CTRL_W-1:0] rr_ctrl;

    logic              ex_valid_q;
    logic [31:0]       ex_src1_q;
    logic [31:0]       ex_src2_q;
    logic [PREG_W-1:0] ex_dst_q;
    logic [TAG_W-1:0]  ex_tag_q;
    logic [CTRL_W-1:0] ex_ctrl_q;

    logic              advance;
    logic              accept;
    logic [31:0]       op1;
    logic [31:0]       op2;

    // Lowest-numbered matching writeback wins; an unused source reads as zero.
    function automatic logic [31:0] select_operand(
        input logic                      used,
        input logic [PREG_W-1:0]         src,
        input logic [31:0]               prf_val,
        input logic [NUM_FUS-1:0]        bpv,
        input logic [NUM_FUS*PREG_W-1:0] bpd,
        input logic [NUM_FUS*32-1:0]     bpval
    );
        logic [31:0] v;
        logic        hit;
        v   = prf_val;
        hit = 1'b0;
        for (int j = 0; j < int'(NUM_FUS); j++) begin
            if (!hit && bpv[j] && (bpd[j*PREG_W +: PREG_W] == src)) begin
                v   = bpval[j*32 +: 32];
                hit = 1'b1;
            end
        end
        if (!used) begin
            v = 32'h0;
        end
        return v;
    endfunction

    always_comb begin
        advance = rr_valid && (!ex_valid_q || io.ex_ready);
        accept  = io.iss_valid && io.iss_ready;
        op1     = select_operand(rr_src1_used, rr_src1_reg, io.prf_src1_val,
                                 io.bp_valid, io.bp_dst_reg, io.bp_val);
        op2     = select_operand(rr_src2_used, rr_src2_reg, io.prf_src2_val,
                                 io.bp_valid, io.bp_dst_reg, io.bp_val);
    end

    assign io.iss_ready    = !io.flush && (!rr_valid || advance);
    assign io.prf_src1_reg = rr_src1_reg;
    assign io.prf_src2_reg = rr_src2_reg;

    assign io.ex_valid     = ex_valid_q;
    assign io.ex_src1_val  = ex_src1_q;
    assign io.ex_src2_val  = ex_src2_q;
    assign io.ex_dst_reg   = ex_dst_q;
    assign io.ex_tag       = ex_tag_q;
    assign io.ex_ctrl      = ex_ctrl_q;

    // RR slot: refills on accept, empties when its uop moves to OUT; flush drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_valid     <= 1'b0;
            rr_src1_reg  <= '0;
            rr_src2_reg  <= '0;
            rr_src1_used <= 1'b0;
            rr_src2_used <= 1'b0;
            rr_dst_reg   <= '0;
            rr_tag       <= '0;
            rr_ctrl      <= '0;
        end else if (io.flush) begin
            rr_valid <= 1'b0;
        end else if (accept) begin
            rr_valid     <= 1'b1;
            rr_src1_reg  <= io.iss_src1_reg;
            rr_src2_reg  <= io.iss_src2_reg;
            rr_src1_used <= io.iss_src1_used;
            rr_src2_used <= io.iss_src2_used;
            rr_dst_reg   <= io.iss_dst_reg;
            rr_tag       <= io.iss_tag;
            rr_ctrl      <= io.iss_ctrl;
        end else if (advance) begin
            rr_valid <= 1'b0;
        end
    end

    // OUT slot: operands are captured once on advance and held until execute takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_src1_q  <= '0;
            ex_src2_q  <= '0;
            ex_dst_q   <= '0;
            ex_tag_q   <= '0;
            ex_ctrl_q  <= '0;
        end else if (io.flush) begin
            ex_valid_q <= 1'b0;
        end else if (advance) begin
            ex_valid_q <= 1'b1;
            ex_src1_q  <= op1;
            ex_src2_q  <= op2;
            ex_dst_q   <= rr_dst_reg;
            ex_tag_q   <= rr_tag;
            ex_ctrl_q  <= rr_ctrl;
        end else if (io.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Read-side initiator for the physical register file; one instance per functional unit lane.
- Accepts an issued uop and drives its source preg indices to the PRF read port.
- Merges same-cycle execute writeback results (bypass), since PRF writes only become visible after the clock edge.
- Registers the uop with operand values toward its execute unit, using valid/ready backpressure and flush.

Parameters:
- NUM_FUS, 4: number of execute writeback buses snooped for bypass.
- NUM_PREGS, 64: physical register count.
- PREG_W, $clog2(NUM_PREGS): preg index width.
- TAG_W, 6: ROB tag width.
- CTRL_W, 16: opaque uop control field width, passed through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- iss_valid  in  1  issued uop valid.
- iss_ready  out  1  stage can accept the uop this cycle.
- iss_src1_reg  in  PREG_W  source 1 preg.
- iss_src2_reg  in  PREG_W  source 2 preg.
- iss_src1_used  in  1  source 1 is read.
- iss_src2_used  in  1  source 2 is read.
- iss_dst_reg  in  PREG_W  destination preg.
- iss_tag  in  TAG_W  ROB tag.
- iss_ctrl  in  CTRL_W  opaque control.
- prf_src1_reg  out  PREG_W  PRF read address 1 (reg_read_phys_reg_file_if src1_reg).
- prf_src2_reg  out  PREG_W  PRF read address 2.
- prf_src1_val  in  32  PRF read data 1, combinational.
- prf_src2_val  in  32  PRF read data 2, combinational.
- bp_valid  in  NUM_FUS  execute writeback valid per FU (ex_valid).
- bp_dst_reg  in  NUM_FUS*PREG_W  writeback preg per FU, FU j at bits [j*PREG_W +: PREG_W].
- bp_val  in  NUM_FUS*32  writeback value per FU, FU j at bits [j*32 +: 32].
- flush  in  1  squash all in-flight uops.
- ex_valid  out  1  uop with operands valid to execute.
- ex_ready  in  1  execute accepts.
- ex_src1_val  out  32  operand 1.
- ex_src2_val  out  32  operand 2.
- ex_dst_reg  out  PREG_W  destination preg.
- ex_tag  out  TAG_W  ROB tag.
- ex_ctrl  out  CTRL_W  control.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Two registered slots:
  - RR slot: rr_valid plus the uop fields. prf_src*_reg are driven from the RR slot's registered src fields.
  - OUT slot: ex_* registers.
- Reset: rr_valid=0, ex_valid=0, and every ex_* data output is 0. prf_src*_reg are 0.
- advance = rr_valid && (!ex_valid || ex_ready).
- iss_ready = !flush && (!rr_valid || advance), computed combinationally.
- Issue handshake: iss_valid && iss_ready at edge N loads the RR slot.
- RR to OUT: on advance at edge N+1, the OUT slot loads. ex_valid is high from N+1. Minimum latency is 1 cycle in RR; throughput is 1 uop/cycle.
- Operand select per source s, evaluated on the advance cycle:
  - If src_used=0, the operand is 32'h0.
  - Otherwise, if any j has bp_valid[j] && bp_dst_reg[j]==src_reg, use bp_val[j]. If several match, the lowest j wins.
  - Otherwise use prf_src_val.
- Stall in RR: the PRF is re-read every cycle, so a writeback that lands during the stall is seen via bypass in its own cycle or via the PRF afterwards. Captured OUT operands are never re-read.
- OUT hold: while ex_valid && !ex_ready, all ex_* outputs stay stable.
- ex_valid falls after ex_ready unless advance refills the slot in the same cycle. Simultaneous drain and refill is a back-to-back transfer with no bubble.
- Flush has priority over everything. At the edge, rr_valid=0 and ex_valid=0. Any issue presented that cycle is dropped. Data registers may keep stale values.
- Flush and rst with a stalled OUT slot: the slot is discarded. ex_ready is ignored that cycle.
- Preg 0 gets no special treatment.

Test Plan:
- Reset, then PRF[5]=32'hA5A5_0001 and PRF[9]=32'h0000_0042. Issue src1=5, src2=9, dst=12, tag=3, with ex_ready=1 -> ex_valid one cycle after acceptance, ex_src1_val=A5A5_0001, ex_src2_val=0000_0042, ex_dst_reg=12, ex_tag=3.
- Issue src1=7 with PRF[7]=0. In the advance cycle, bp_valid[2]=1, bp_dst_reg[2]=7, bp_val[2]=32'hDEAD_BEEF -> ex_src1_val=DEAD_BEEF.
- FU1 and FU3 both write preg 7 in the same cycle, with values 1 and 3 -> operand=1.
- Hold ex_ready=0 for 3 cycles with 3 uops issued back to back -> OUT stable, RR full, iss_ready=0 after the second accept. Release ex_ready -> uops emerge in order, one per cycle, with no loss.
- Stalled RR with src2=20 while PRF[20] is written mid-stall to 32'h1234 -> after release, ex_src2_val=32'h1234.
- With both slots full, assert flush for 1 cycle together with a new iss_valid -> next cycle ex_valid=0, rr_valid=0, and the new uop never appears. Repeat the same state with rst -> all ex_* outputs are 0.
- src1_used=0 and src2_used=0, with a matching bypass present -> both operands are 0.
